data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's MEM stage. Accepts load/store requests from the core, applies a configurable number of wait states, and performs word, halfword or byte accesses on an internal word array.
- Returns sign- or zero-extended load data, and drives a Stall line that the hazard logic uses to freeze the pipeline until the access completes.
- Sits between the EX/MEM register outputs and the MEM/WB register inputs.

Parameters:
- ADDR_BITS, 10, log2 of the number of 32-bit words in the array (1024 words).
- WAIT_CYCLES, 2, wait states inserted between request acceptance and completion (0..15).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Address  input  32  byte address from ALUResult.
- WriteData  input  32  store data; the low-order bytes/halfword are used for sub-word stores.
- MemWrite  input  1  store request.
- MemRead  input  1  load request.
- Size  input  2  00 = word, 01 = halfword, 10 = byte, 11 = reserved (treated as word).
- LoadUnsigned  input  1  1 = zero-extend sub-word loads (lbu/lhu); 0 = sign-extend.
- ReadData  output  32  load result; valid in the DONE cycle and held until the next DONE.
- Stall  output  1  pipeline freeze request.
- Done  output  1  one-cycle completion pulse.
- MisalignErr  output  1  one-cycle pulse, coincident with Done, for a misaligned access.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, wait counter=0, ReadData=0, Done=0, MisalignErr=0, captured request cleared. Reset does not clear the memory array.
- Request: req = MemRead | MemWrite. If both are high, the store wins and the load is ignored; ReadData is left unchanged.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if req is high, capture Address, WriteData, Size, LoadUnsigned and the op, then go to WAIT. If WAIT_CYCLES=0, go directly to DONE and perform the access on this edge.
  - WAIT: the counter counts 1..WAIT_CYCLES. When count==WAIT_CYCLES, perform the access on that edge and go to DONE. Request inputs are ignored in WAIT; the captured copy is used.
  - DONE: Done=1 for exactly one cycle, then return to IDLE. Request inputs are ignored in DONE. A new request is sampled the following IDLE cycle.
- Stall is combinational: Stall = (state==IDLE & req) | (state==WAIT). Stall is 0 in DONE and in IDLE with no request.
- Latency: request first seen in IDLE at cycle 0 → Done at cycle WAIT_CYCLES+1. Stall is high for cycles 0..WAIT_CYCLES.
- Indexing: word index = Address[ADDR_BITS+1:2]. Upper address bits are ignored, so the array wraps modulo 4*2^ADDR_BITS bytes.
- Byte lanes are big-endian:
  - Byte offset 0 → bits 31:24, 1 → 23:16, 2 → 15:8, 3 → 7:0.
  - Halfword offset 0 → bits 31:16, offset 2 → bits 15:0.
- Stores:
  - Word: writes all 32 bits.
  - Halfword: writes WriteData[15:0] into the addressed half; the other bytes are unchanged.
  - Byte: writes WriteData[7:0] into the addressed lane; the other bytes are unchanged.
- Loads:
  - Word: returns the whole word.
  - Halfword: returns the selected half, extended to 32 bits.
  - Byte: returns the selected byte, extended to 32 bits.
  - Extension uses the captured LoadUnsigned.
- Alignment: a word access needs Address[1:0]==00; a halfword access needs Address[0]==0.
  - On a misaligned access: no array write, ReadData=0, MisalignErr=1 in the DONE cycle.
  - The FSM timing is identical to an aligned access.
- Store completion: ReadData is not updated and MisalignErr follows the alignment rule.
- Reset mid-operation (in WAIT, before the access edge): the access is aborted, no write is committed, and no Done is issued.
- Reset asserted on the access edge: Reset has priority and the write is not committed.

Test Plan:
- Reset, then sw 0x12345678 @0x10 (Size=00), then lw @0x10, with WAIT_CYCLES=2 → each access has Stall high 3 cycles and Done at cycle 3; load returns ReadData=0x12345678.
- sb 0xAB @0x11, then lbu @0x11 and lb @0x11 → word @0x10 reads 0x12AB5678; lbu returns 0x000000AB; lb returns 0xFFFFFFAB.
- sh 0x8001 @0x12, then lh @0x12 and lhu @0x12 → lh returns 0xFFFF8001; lhu returns 0x00008001; word @0x10 reads 0x12AB8001.
- lw @0x13 and sh @0x11 → MisalignErr=1 with Done; ReadData=0; word @0x10 is unchanged.
- sw 0xDEADBEEF @0x20, with Reset pulsed in the first WAIT cycle → no Done; Stall drops to 0 after reset; lw @0x20 returns the previous value.
- WAIT_CYCLES=0, MemRead and MemWrite both high with 0x55 @0x0 → Stall high 1 cycle; Done in the next cycle; the store is committed; ReadData keeps its prior value.
- Address 0x1000 with ADDR_BITS=10 → aliases word 0.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Purpose : MEM-stage data memory with wait states, sub-word big-endian access
// Revision: 1.0
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  Size,
  input  logic        LoadUnsigned,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        MisalignErr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int         c_depth     = 1 << ADDR_BITS;
  localparam logic [3:0] c_wait      = 4'(WAIT_CYCLES);
  localparam bit         c_zero_wait = (WAIT_CYCLES == 0);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_nxt;
  logic                   w_capture;
  logic [ADDR_BITS+1:0]   r_addr;
  logic [31:0]            r_wdata;
  logic [1:0]             r_size;
  logic                   r_unsigned;
  logic                   r_wr;
  logic                   r_done;
  logic                   r_misalign;
  logic [31:0]            r_mem [0:c_depth-1];

  logic                   w_req;
  logic                   w_use_in;
  logic                   w_fire;
  logic [ADDR_BITS+1:0]   w_addr;
  logic [31:0]            w_wdata;
  logic [1:0]             w_size;
  logic                   w_unsigned;
  logic                   w_wr;
  logic [ADDR_BITS-1:0]   w_idx;
  logic [1:0]             w_off;
  logic                   w_misalign;
  logic [31:0]            w_old;
  logic [31:0]            w_load;
  logic [31:0]            w_new;
  logic [15:0]            w_half;
  logic [7:0]             w_byte;
  logic                   w_unused_addr;

  assign w_unused_addr = &{1'b0, Address[31:ADDR_BITS+2]};

  assign w_req = MemRead | MemWrite;

  // A zero-wait access happens on the acceptance edge, so it must use the live inputs
  assign w_use_in   = (r_state == ST_IDLE);
  assign w_addr     = w_use_in ? Address[ADDR_BITS+1:0] : r_addr;
  assign w_wdata    = w_use_in ? WriteData    : r_wdata;
  assign w_size     = w_use_in ? Size         : r_size;
  assign w_unsigned = w_use_in ? LoadUnsigned : r_unsigned;
  assign w_wr       = w_use_in ? MemWrite     : r_wr;

  assign w_fire = (c_zero_wait && r_state == ST_IDLE && w_req) ||
                  (r_state == ST_WAIT && r_cnt == c_wait);

  assign w_idx = w_addr[ADDR_BITS+1:2];
  assign w_off = w_addr[1:0];
  assign w_old = r_mem[w_idx];

  always_comb begin
    case (w_size)
      2'b01:   w_misalign = w_off[0];
      2'b10:   w_misalign = 1'b0;
      default: w_misalign = (w_off != 2'b00);
    endcase
  end

  // Big-endian lanes: offset 0 is the most significant byte
  always_comb begin
    w_half = w_off[1] ? w_old[15:0] : w_old[31:16];
    case (w_off)
      2'd0:    w_byte = w_old[31:24];
      2'd1:    w_byte = w_old[23:16];
      2'd2:    w_byte = w_old[15:8];
      default: w_byte = w_old[7:0];
    endcase
    case (w_size)
      2'b01:   w_load = w_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      2'b10:   w_load = w_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      default: w_load = w_old;
    endcase
  end

  always_comb begin
    w_new = w_old;
    case (w_size)
      2'b01: begin
        if (w_off[1]) w_new[15:0]  = w_wdata[15:0];
        else          w_new[31:16] = w_wdata[15:0];
      end
      2'b10: begin
        case (w_off)
          2'd0:    w_new[31:24] = w_wdata[7:0];
          2'd1:    w_new[23:16] = w_wdata[7:0];
          2'd2:    w_new[15:8]  = w_wdata[7:0];
          default: w_new[7:0]   = w_wdata[7:0];
        endcase
      end
      default: w_new = w_wdata;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_capture = 1'b1;
          if (c_zero_wait) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == c_wait) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign Stall       = ((r_state == ST_IDLE) && w_req) || (r_state == ST_WAIT);
  assign Done        = r_done;
  assign MisalignErr = r_misalign;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wr       <= 1'b0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      ReadData   <= 32'h0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_done     <= w_fire;
      r_misalign <= w_fire & w_misalign;
      if (w_capture) begin
        r_addr     <= Address[ADDR_BITS+1:0];
        r_wdata    <= WriteData;
        r_size     <= Size;
        r_unsigned <= LoadUnsigned;
        r_wr       <= MemWrite;
      end
      if (w_fire && !w_wr) begin
        ReadData <= w_misalign ? 32'h0 : w_load;
      end
    end
  end

  // Array is not reset; Reset only blocks a commit on the same edge
  always_ff @(posedge Clk) begin
    if (!Reset && w_fire && w_wr && !w_misalign) begin
      r_mem[w_idx] <= w_new;
    end
  end

endmodule
`default_nettype wire
